// File: rtl/nearest_neighbor_zoom_out_2x.sv
// Streaming 2x decimator: keeps the top-left pixel of each 2x2 block, or the rounded
// block average when BLOCK_AVG_EN is defined.
module nearest_neighbor_zoom_out_2x #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  pixel_in,
    output logic        in_ready,
    output logic [7:0]  pixel_out,
    output logic        out_valid,
    output logic [15:0] out_count,
    output logic        busy,
    output logic        done
);
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic [7:0]      pixel_out_q;
    logic            out_valid_q;
    logic [15:0]     out_count_q;
    logic            done_q;

    logic            beat_w;
    logic            trig_w;
    logic [7:0]      pix_w;

    assign in_ready  = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign beat_w    = in_valid & in_ready;
    assign pixel_out = pixel_out_q;
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign done      = done_q;

`ifdef BLOCK_AVG_EN
    localparam int LBN = IMG_W / 2;
    localparam int LBW = (LBN > 1) ? $clog2(LBN) : 1;

    logic [7:0]     hold_q;
    logic [8:0]     linebuf [LBN];
    logic [LBW-1:0] lb_idx;
    logic [9:0]     sum_w;

    assign lb_idx = LBW'(col_q >> 1);
    assign sum_w  = {1'b0, linebuf[lb_idx]} + {2'b00, hold_q} + {2'b00, pixel_in};
    assign pix_w  = 8'((sum_w + 10'd2) >> 2);
    assign trig_w = beat_w & row_q[0] & col_q[0];

    // Left pixel of each horizontal pair, on both rows of the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= 8'd0;
        end else if (beat_w && !col_q[0]) begin
            hold_q <= pixel_in;
        end
    end

    // Top-row pair sums wait here until the matching bottom-row pair arrives.
    always_ff @(posedge clk) begin
        if (beat_w && !row_q[0] && col_q[0]) begin
            linebuf[lb_idx] <= {1'b0, hold_q} + {1'b0, pixel_in};
        end
    end
`else
    assign pix_w  = pixel_in;
    assign trig_w = beat_w & ~row_q[0] & ~col_q[0];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            pixel_out_q <= 8'd0;
            out_valid_q <= 1'b0;
            out_count_q <= 16'd0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= RUN;
                        col_q       <= '0;
                        row_q       <= '0;
                        out_count_q <= 16'd0;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                            if (row_q == LAST_ROW) begin
                                state_q <= DONE;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        if (trig_w) begin
                            out_valid_q <= 1'b1;
                            pixel_out_q <= pix_w;
                            out_count_q <= out_count_q + 16'd1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nearest_neighbor_zoom_out_2x.sv
// Scoreboard bench for the 2x zoom-out block: a 4x4 instance for the directed frames
// and a default 160x120 instance for the full-size frame.
module tb_nearest_neighbor_zoom_out_2x;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int BW = 160;
    localparam int BH = 120;
`ifdef BLOCK_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, in_valid_a = 1'b0;
    logic [7:0]  pixel_in_a = 8'd0;
    logic        in_ready_a, out_valid_a, busy_a, done_a;
    logic [7:0]  pixel_out_a;
    logic [15:0] out_count_a;

    logic        start_b = 1'b0, in_valid_b = 1'b0;
    logic [7:0]  pixel_in_b = 8'd0;
    logic        in_ready_b, out_valid_b, busy_b, done_b;
    logic [7:0]  pixel_out_b;
    logic [15:0] out_count_b;

    nearest_neighbor_zoom_out_2x #(.IMG_W(W), .IMG_H(H)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .in_valid(in_valid_a),
        .pixel_in(pixel_in_a), .in_ready(in_ready_a), .pixel_out(pixel_out_a),
        .out_valid(out_valid_a), .out_count(out_count_a), .busy(busy_a), .done(done_a)
    );

    nearest_neighbor_zoom_out_2x u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .in_valid(in_valid_b),
        .pixel_in(pixel_in_b), .in_ready(in_ready_b), .pixel_out(pixel_out_b),
        .out_valid(out_valid_b), .out_count(out_count_b), .busy(busy_b), .done(done_b)
    );

    int total = 0;
    int bad = 0;
    int done_seen_a = 0;
    int done_seen_b = 0;
    int strobes_b = 0;
    int cnt_a = 0;
    int cnt_b = 0;
    logic drv_trig_a = 1'b0, drv_trig_b = 1'b0;
    logic exp_v_a = 1'b0, exp_v_b = 1'b0;
    logic [23:0] qa[$];
    logic [23:0] qb[$];
    logic [7:0] fa [16];
    logic [7:0] t2 [16] = '{8'd10, 8'd20, 8'd30, 8'd30, 8'd30, 8'd41, 8'd30, 8'd30,
                            8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic logic [7:0] avg4(input int a, input int b, input int c, input int d);
        int s;
        s = a + b + c + d + 2;
        return 8'(s >> 2);
    endfunction

    function automatic logic [7:0] ramp(input int i);
        return 8'((i * 7 + i / BW) % 256);
    endfunction

    // out_valid must follow the bench's own record of triggering beats by one cycle.
    always @(posedge clk) begin
        exp_v_a <= drv_trig_a;
        exp_v_b <= drv_trig_b;
    end

    always @(negedge clk) begin
        chk("valid_a", {31'd0, out_valid_a}, {31'd0, exp_v_a});
        if (out_valid_a) begin
            if (qa.size() == 0) begin
                chk("extra_a", {31'd0, out_valid_a}, 32'd0);
            end else begin
                chk("pix_a", {24'd0, pixel_out_a}, {24'd0, qa[0][7:0]});
                chk("cnt_a", {16'd0, out_count_a}, {16'd0, qa[0][23:8]});
                void'(qa.pop_front());
            end
        end
        chk("valid_b", {31'd0, out_valid_b}, {31'd0, exp_v_b});
        if (out_valid_b) begin
            strobes_b <= strobes_b + 1;
            if (qb.size() == 0) begin
                chk("extra_b", {31'd0, out_valid_b}, 32'd0);
            end else begin
                chk("pix_b", {24'd0, pixel_out_b}, {24'd0, qb[0][7:0]});
                chk("cnt_b", {16'd0, out_count_b}, {16'd0, qb[0][23:8]});
                void'(qb.pop_front());
            end
        end
        if (done_a) done_seen_a <= done_seen_a + 1;
        if (done_b) done_seen_b <= done_seen_b + 1;
    end

    // Entered and left at posedge+1. Drives beats 0..stop_at-1 of fa[].
    task automatic run_frame_a(input bit gaps, input int stop_at, input int mid_start);
        int ds0;
        int r, c;
        bit trig;
        logic [7:0] e;
        ds0 = done_seen_a;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < stop_at; i++) begin
            for (int k = 0; k < 8 && gaps && $urandom_range(1) == 0; k++) begin
                in_valid_a = 1'b0;
                drv_trig_a = 1'b0;
                pixel_in_a = 8'($urandom_range(255));
                @(posedge clk); #1;
            end
            r = i / W;
            c = i % W;
            if (AVG) begin
                trig = (r % 2 == 1) && (c % 2 == 1);
                e = trig ? avg4(fa[i-W-1], fa[i-W], fa[i-1], fa[i]) : 8'd0;
            end else begin
                trig = (r % 2 == 0) && (c % 2 == 0);
                e = fa[i];
            end
            if (trig) begin
                cnt_a++;
                qa.push_back({16'(cnt_a), e});
            end
            in_valid_a = 1'b1;
            pixel_in_a = fa[i];
            start_a = (i == mid_start);
            drv_trig_a = trig;
            @(posedge clk); #1;
            start_a = 1'b0;
        end
        in_valid_a = 1'b0;
        drv_trig_a = 1'b0;
        if (stop_at == W * H) begin
            @(negedge clk);
            chk("busy_in_done", {31'd0, busy_a}, 32'd1);
            chk("done_early", {31'd0, done_a}, 32'd0);
            chk("ready_in_done", {31'd0, in_ready_a}, 32'd0);
            @(negedge clk);
            chk("done_pulse", {31'd0, done_a}, 32'd1);
            chk("count_end", {16'd0, out_count_a}, 32'd4);
            chk("busy_after", {31'd0, busy_a}, 32'd0);
            @(negedge clk);
            chk("done_fall", {31'd0, done_a}, 32'd0);
            @(posedge clk); #1;
            chk("done_once", 32'(done_seen_a - ds0), 32'd1);
            chk("queue_empty_a", 32'(qa.size()), 32'd0);
        end
    endtask

    task automatic check_reset_a();
        chk("rst_pix", {24'd0, pixel_out_a}, 32'd0);
        chk("rst_valid", {31'd0, out_valid_a}, 32'd0);
        chk("rst_count", {16'd0, out_count_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_ready", {31'd0, in_ready_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
    endtask

    initial begin
        int r, c, ds;
        bit trig, seen;
        logic [7:0] e;

        @(negedge clk);
        check_reset_a();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: ramp 0..15, back-to-back
        for (int i = 0; i < 16; i++) fa[i] = 8'(i);
        run_frame_a(1'b0, 16, -1);

        // 2: averaging pattern
        for (int i = 0; i < 16; i++) fa[i] = t2[i];
        run_frame_a(1'b0, 16, -1);

        // 3: ramp with random in_valid gaps
        for (int i = 0; i < 16; i++) fa[i] = 8'(i);
        run_frame_a(1'b1, 16, -1);

        // 4: reset mid-frame, then a fresh frame
        run_frame_a(1'b0, 7, -1);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_a();
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("queue_after_reset", 32'(qa.size()), 32'd0);
        @(posedge clk); #1;
        run_frame_a(1'b0, 16, -1);

        // 5: in_valid in IDLE ignored, start mid-RUN ignored
        for (int k = 0; k < 4; k++) begin
            in_valid_a = 1'b1;
            pixel_in_a = 8'd77;
            @(negedge clk);
            chk("idle_ready", {31'd0, in_ready_a}, 32'd0);
            chk("idle_busy", {31'd0, busy_a}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid_a = 1'b0;
        run_frame_a(1'b0, 16, 5);

        // 6: full-size frame on the default-parameter instance
        ds = done_seen_b;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        cnt_b = 0;
        for (int i = 0; i < BW * BH; i++) begin
            r = i / BW;
            c = i % BW;
            if (AVG) begin
                trig = (r % 2 == 1) && (c % 2 == 1);
                e = trig ? avg4(ramp(i-BW-1), ramp(i-BW), ramp(i-1), ramp(i)) : 8'd0;
            end else begin
                trig = (r % 2 == 0) && (c % 2 == 0);
                e = ramp(i);
            end
            if (trig) begin
                cnt_b++;
                qb.push_back({16'(cnt_b), e});
            end
            in_valid_b = 1'b1;
            pixel_in_b = ramp(i);
            drv_trig_b = trig;
            @(posedge clk); #1;
        end
        in_valid_b = 1'b0;
        drv_trig_b = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (done_b) seen = 1'b1;
        end
        chk("b_done_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        chk("b_out_count", {16'd0, out_count_b}, 32'd4800);
        chk("b_strobes", 32'(strobes_b), 32'd4800);
        chk("b_done_once", 32'(done_seen_b - ds), 32'd1);
        chk("queue_empty_b", 32'(qb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
